// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator. It follows the pixel, line and frame position
// using the active flags from the timing generator. It produces a solid
// colour, colour bars, a checkerboard, a gradient or scrolling bars. The
// outputs are registered, so each pixel appears one clock after its position
// is presented.
module vga_pattern_gen #(
  parameter int COLOR_WIDTH = 4,
  parameter int H_ACTIVE    = 640,
  parameter int X_WIDTH     = 12,
  parameter int CHECK_LOG2  = 5,
  parameter int GRAD_SHIFT  = 5,
  parameter int SCROLL_LOG2 = 3
) (
  input  logic                     pxl_clk,
  input  logic                     pxl_rst,
  input  logic                     horz_active,
  input  logic                     vert_active,
  input  logic                     frame_active,
  input  logic [2:0]               mode_sel,
  input  logic [3*COLOR_WIDTH-1:0] solid_rgb,
  output logic [COLOR_WIDTH-1:0]   rgb_red,
  output logic [COLOR_WIDTH-1:0]   rgb_green,
  output logic [COLOR_WIDTH-1:0]   rgb_blue,
  output logic                     out_active
);

  localparam int RGB_W   = 3 * COLOR_WIDTH;
  localparam int FRAME_W = SCROLL_LOG2 + 3;
  localparam int BAR_W   = H_ACTIVE >> 3;

  localparam logic [X_WIDTH-1:0] X_MAX    = '1;
  localparam logic [X_WIDTH-1:0] X_ONE    = X_WIDTH'(1);
  localparam logic [X_WIDTH-1:0] BAR_LAST = X_WIDTH'(BAR_W - 1);
  localparam logic [2:0]         BAR_MAX  = 3'd7;

  typedef enum logic [2:0] {
    MODE_SOLID  = 3'd0,
    MODE_BARS   = 3'd1,
    MODE_CHECK  = 3'd2,
    MODE_GRAD   = 3'd3,
    MODE_SCROLL = 3'd4
  } mode_e;

  // Order of the bar colours from left to right: white, yellow, cyan, green,
  // magenta, red, blue, black. Bit 2 is red, bit 1 is green and bit 0 is blue.
  function automatic logic [2:0] bar_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'd7;
      3'd1:    code = 3'd6;
      3'd2:    code = 3'd3;
      3'd3:    code = 3'd2;
      3'd4:    code = 3'd5;
      3'd5:    code = 3'd4;
      3'd6:    code = 3'd1;
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  function automatic logic [RGB_W-1:0] expand_code(input logic [2:0] code);
    return {{COLOR_WIDTH{code[2]}}, {COLOR_WIDTH{code[1]}}, {COLOR_WIDTH{code[0]}}};
  endfunction

  logic               h_q, h_d;
  logic               v_q, v_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [X_WIDTH-1:0] y_q, y_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [X_WIDTH-1:0] bar_pix_q, bar_pix_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  mode_e              mode_q, mode_d;
  logic [RGB_W-1:0]   solid_q, solid_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               out_active_q, out_active_d;

  logic               line_end;
  logic               frame_end;
  logic [2:0]         scroll_idx;
  logic [COLOR_WIDTH-1:0] grad_val;
  logic [RGB_W-1:0]   pix_rgb;

  // Position tracking: edge detectors, the x and y counters, the frame counter
  // and the bar counters.
  always_comb begin
    // NOTE: every signal gets a default first, so a path that is not covered
    // keeps its value through the _q term and never infers a latch.
    h_d       = horz_active;
    v_d       = vert_active;
    line_end  = h_q & ~horz_active;
    frame_end = v_q & ~vert_active;
    x_d       = x_q;
    y_d       = y_q;
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    frame_d   = frame_q + {{(FRAME_W-1){1'b0}}, frame_end};

    if (!horz_active) begin
      x_d = '0;
    end else if (frame_active && (x_q != X_MAX)) begin
      x_d = x_q + X_ONE;
    end

    if (!vert_active) begin
      y_d = '0;
    end else if (line_end && (y_q != X_MAX)) begin
      y_d = y_q + X_ONE;
    end

    // The bar counters step alongside x, so no divide by BAR_W is needed.
    // bar_idx stops at 7, so any pixels past the last bar stay in that bar.
    if (!horz_active) begin
      bar_pix_d = '0;
      bar_idx_d = '0;
    end else if (frame_active) begin
      if (bar_pix_q == BAR_LAST) begin
        bar_pix_d = '0;
        if (bar_idx_q != BAR_MAX) begin
          bar_idx_d = bar_idx_q + 3'd1;
        end
      end else begin
        bar_pix_d = bar_pix_q + X_ONE;
      end
    end
  end

  // Mode and colour latch. It is open only during vertical blanking, so a new
  // selection starts cleanly at the top of a frame.
  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    if (!vert_active) begin
      mode_d  = mode_e'(mode_sel);
      solid_d = solid_rgb;
    end
  end

  // Pixel colour for the current position. Blanking forces the colour to black.
  always_comb begin
    scroll_idx = bar_idx_q + frame_q[SCROLL_LOG2+2:SCROLL_LOG2];
    grad_val   = x_q[GRAD_SHIFT+COLOR_WIDTH-1:GRAD_SHIFT];
    pix_rgb    = '0;
    case (mode_q)
      MODE_SOLID:  pix_rgb = solid_q;
      MODE_BARS:   pix_rgb = expand_code(bar_code(bar_idx_q));
      MODE_CHECK:  pix_rgb = (x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]) ? '1 : '0;
      MODE_GRAD:   pix_rgb = {grad_val, grad_val, grad_val};
      MODE_SCROLL: pix_rgb = expand_code(bar_code(scroll_idx));
      default:     pix_rgb = '0;
    endcase
    rgb_d        = frame_active ? pix_rgb : '0;
    out_active_d = frame_active;
  end

  // State and output registers.
  always_ff @(posedge pxl_clk or negedge pxl_rst) begin
    if (!pxl_rst) begin
      h_q          <= 1'b0;
      v_q          <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_q      <= '0;
      bar_pix_q    <= '0;
      bar_idx_q    <= '0;
      mode_q       <= MODE_SOLID;
      solid_q      <= '0;
      rgb_q        <= '0;
      out_active_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the values from
      // before the edge, whatever order the statements are written in.
      h_q          <= h_d;
      v_q          <= v_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_q      <= frame_d;
      bar_pix_q    <= bar_pix_d;
      bar_idx_q    <= bar_idx_d;
      mode_q       <= mode_d;
      solid_q      <= solid_d;
      rgb_q        <= rgb_d;
      out_active_q <= out_active_d;
    end
  end

  assign rgb_red    = rgb_q[3*COLOR_WIDTH-1:2*COLOR_WIDTH];
  assign rgb_green  = rgb_q[2*COLOR_WIDTH-1:COLOR_WIDTH];
  assign rgb_blue   = rgb_q[COLOR_WIDTH-1:0];
  assign out_active = out_active_q;

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised VGA test-pattern generator. Successor to the fixed solid-colour generator.
- Sits between the VGA timing generator, which supplies the active flags, and the DAC/pin stage.
- Tracks pixel/line/frame position internally from the active flags. Produces one of several selectable patterns, including an animated one.
- Outputs are registered, with one cycle of latency.

Parameters:
- COLOR_WIDTH, 4, bits per colour channel.
- H_ACTIVE, 640, active pixels per line; must be ≥ 8.
- X_WIDTH, 12, width of the pixel and line counters.
- CHECK_LOG2, 5, log2 of the checkerboard square size in pixels.
- GRAD_SHIFT, 5, right shift applied to x to form the gradient intensity.
- SCROLL_LOG2, 3, log2 of the frames per bar step in scroll mode.

Ports:
- pxl_clk, in, 1, pixel clock.
- pxl_rst, in, 1, reset; asynchronous, active-low.
- horz_active, in, 1, high during active pixels of a line.
- vert_active, in, 1, high during active lines of a frame.
- frame_active, in, 1, horz_active AND vert_active, from the timing generator.
- mode_sel, in, 3, pattern select; sampled only during vertical blanking.
- solid_rgb, in, 3*COLOR_WIDTH, solid colour {R,G,B} for mode 0; sampled with mode_sel.
- rgb_red, out, COLOR_WIDTH, red channel.
- rgb_green, out, COLOR_WIDTH, green channel.
- rgb_blue, out, COLOR_WIDTH, blue channel.
- out_active, out, 1, frame_active delayed one cycle; qualifies the rgb outputs.

Behaviour:
- Reset (pxl_rst low, asynchronous): all counters, edge registers and the mode/colour latch clear to 0. All rgb outputs and out_active are 0. Registered mode resets to 0 (solid), colour to 0 (black).
- Edge detection: horz_active and vert_active are each registered once.
  - Line end = horz_active falling edge.
  - Frame end = vert_active falling edge.
- x counter:
  - Increments on each cycle with frame_active=1.
  - Clears on any cycle with horz_active=0.
  - Saturates at 2^X_WIDTH-1.
- y counter:
  - Increments at line end while vert_active=1.
  - Clears while vert_active=0.
  - Saturates at 2^X_WIDTH-1.
- frame counter: SCROLL_LOG2+3 bits, increments at frame end, wraps.
- Bar tracking: no divider.
  - BAR_W = H_ACTIVE>>3.
  - Bar pixel counter counts 0..BAR_W-1 during frame_active; at BAR_W-1 it wraps to 0 and bar_idx increments.
  - bar_idx saturates at 7; pixels beyond 8*BAR_W stay in bar 7.
  - Both bar counters clear with x.
- Mode/colour latch: loads mode_sel and solid_rgb on every cycle with vert_active=0. Frozen while vert_active=1, so a change takes effect at the next frame with no tearing.
- Pattern generation, computed from the current-cycle position and registered to outputs:
  - Mode 0, solid: rgb = latched solid_rgb.
  - Mode 1, bars: colour index c = BARS[bar_idx].
    - BARS = {7,6,3,2,5,4,1,0}: white, yellow, cyan, green, magenta, red, blue, black.
    - c[2]→red, c[1]→green, c[0]→blue. Each channel is all-ones or zero.
  - Mode 2, checker: white (all-ones) if x[CHECK_LOG2] XOR y[CHECK_LOG2], else black.
  - Mode 3, gradient: all three channels = x[GRAD_SHIFT+COLOR_WIDTH-1:GRAD_SHIFT]. Wraps naturally when x exceeds the range.
  - Mode 4, scroll: as mode 1 with index (bar_idx + frame_cnt[SCROLL_LOG2+2:SCROLL_LOG2]) mod 8. Bars shift one position every 2^SCROLL_LOG2 frames.
  - Modes 5–7: reserved, output black.
- Blanking: when frame_active=0, the registered rgb is 0 regardless of mode.
- Latency: the pixel at position (x,y) appears on rgb exactly one pxl_clk after the cycle on which frame_active presented it; out_active is aligned with it.
- Simultaneous events: a line end on the last active line coincides with the frame end. y clears (vert_active already 0) and frame_cnt increments in the same cycle.
- Reset mid-frame: counters restart from 0. y is offset until the first vert_active low. The mode latch loads at the next blanking. No X propagation; outputs stay 0 until the first frame_active.

Test Plan:
- Reset mid-line with frame_active=1 → rgb=0 and out_active=0 immediately (asynchronously). Outputs resume 1 cycle after the next frame_active with x=0.
- Mode 0, solid_rgb=12'hA5C, 640x480 timing → every active pixel is R=A, G=5, B=C. Blanking pixels are 0. First active pixel out exactly 1 cycle after frame_active rises.
- Mode 1, H_ACTIVE=640 → pixels 0–79 R=G=B=F; 80–159 yellow (F,F,0); 160–239 cyan; …; 560–639 all 0.
- Mode 2, CHECK_LOG2=5 → (x=0,y=0) black; (32,0) white; (32,32) black; (0,32) white.
- Mode 3, GRAD_SHIFT=5 → x=0 gives 0; x=32 gives 1; x=480 gives F; x=512 wraps to 0.
- Mode 4, SCROLL_LOG2=3 → frames 0–7 pixel 0 white; frames 8–15 pixel 0 yellow. mode_sel changed mid-frame 0→1 → no visible change until the line after the next vertical blanking.
